// File: rtl/axis_tlast_strip_pkg.sv
// Shared types and helpers for the AXIS framing-strip receive path.
// Defines bus widths, the FSM state, the debug view and tkeep decoding.
package axis_tlast_strip_pkg;

  localparam int AXIS_DATA_W = 32;
  localparam int AXIS_KEEP_W = 4;
  localparam int RES_W       = 24;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  typedef struct packed {
    state_t     state;
    logic [1:0] res_count;
    logic [RES_W-1:0] res_data;
  } dbg_t;

  // Returns {legal, n}; only lane-0-contiguous keeps are legal, illegal ones carry n=0.
  function automatic logic [3:0] keep_to_count(input logic [AXIS_KEEP_W-1:0] tkeep);
    logic [3:0] res;
    case (tkeep)
      4'b0000: res = 4'b1_000;
      4'b0001: res = 4'b1_001;
      4'b0011: res = 4'b1_010;
      4'b0111: res = 4'b1_011;
      4'b1111: res = 4'b1_100;
      default: res = 4'b0_000;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/axis_tlast_strip_if.sv
// AXI4-Stream bundle used on both sides of the strip block.
// A beat transfers on a rising clock edge where tvalid && tready; the master holds
// tdata/tkeep/tlast/tvalid stable while tvalid=1 and tready=0, and tready may depend on tvalid.
interface axis_tlast_strip_if;
  import axis_tlast_strip_pkg::*;

  logic [AXIS_DATA_W-1:0] tdata;
  logic [AXIS_KEEP_W-1:0] tkeep;
  logic                   tlast;
  logic                   tvalid;
  logic                   tready;

  modport master (
    output tdata,
    output tkeep,
    output tlast,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tkeep,
    input  tlast,
    input  tvalid,
    output tready
  );

endinterface

// File: rtl/axis_tlast_strip_byte_packer.sv
// Residual byte register plus the 7-byte merge that compacts partial beats into
// whole 32-bit words; the residual is kept with unused upper bytes at zero.
module axis_tlast_strip_byte_packer
  import axis_tlast_strip_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   beat_en,
  input  logic [AXIS_DATA_W-1:0] beat_data,
  input  logic [2:0]             beat_n,
  input  logic                   flush_en,
  output logic                   word_full,
  output logic [AXIS_DATA_W-1:0] word_data,
  output logic [AXIS_DATA_W-1:0] flush_data,
  output logic [2:0]             post_count,
  output logic [1:0]             res_count,
  output logic [RES_W-1:0]       res_data
);

  logic [AXIS_DATA_W-1:0] masked;
  logic [55:0]            merged;
  logic [2:0]             total;

  // Lanes above n are zeroed so the merged vector stays clean above 'total' bytes.
  always_comb begin
    masked = '0;
    for (int i = 0; i < AXIS_KEEP_W; i++) begin
      if (i < int'(beat_n)) masked[8*i +: 8] = beat_data[8*i +: 8];
    end
  end

  assign merged     = {32'b0, res_data} | ({24'b0, masked} << {res_count, 3'b000});
  assign total      = {1'b0, res_count} + beat_n;
  assign word_full  = beat_en && total[2];
  assign word_data  = merged[31:0];
  assign flush_data = {8'b0, res_data};
  assign post_count = beat_en ? {1'b0, total[1:0]} : {1'b0, res_count};

  // total is at most 7, so total-4 and total share the low two bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_count <= '0;
      res_data  <= '0;
    end else if (flush_en) begin
      res_count <= '0;
      res_data  <= '0;
    end else if (beat_en) begin
      res_count <= total[1:0];
      res_data  <= total[2] ? merged[55:32] : merged[23:0];
    end
  end

endmodule

// File: rtl/axis_tlast_strip.sv
// Strips tkeep/tlast framing from a packetised AXIS stream and emits compacted raw words,
// with optional zero-padded flush at packet end, packet/byte counters and a sticky tkeep error.
module axis_tlast_strip
  import axis_tlast_strip_pkg::*;
#(
  parameter bit FLUSH_ON_LAST = 1'b1,
  parameter int COUNT_W       = 32
) (
  input  logic               aclk,
  input  logic               aresetn,
  axis_tlast_strip_if.slave  s_axis,
  axis_tlast_strip_if.master m_axis,
  input  logic               stat_clear,
  output logic [COUNT_W-1:0] pkt_count,
  output logic [COUNT_W-1:0] byte_count,
  output logic               keep_err,
  output dbg_t               dbg
);

  state_t                 state;
  logic                   m_valid;
  logic [AXIS_DATA_W-1:0] m_data;

  logic [3:0]             keep_info;
  logic                   keep_legal;
  logic [2:0]             beat_n;
  logic                   out_free;
  logic                   accept;
  logic                   flush_go;

  logic                   word_full;
  logic [AXIS_DATA_W-1:0] word_data;
  logic [AXIS_DATA_W-1:0] flush_data;
  logic [2:0]             post_count;
  logic [1:0]             res_count;
  logic [RES_W-1:0]       res_data;

  assign keep_info  = keep_to_count(s_axis.tkeep);
  assign keep_legal = keep_info[3];
  assign beat_n     = keep_info[2:0];

  assign out_free      = !m_valid || m_axis.tready;
  assign s_axis.tready = aresetn && (state == ST_RUN) && out_free;
  assign accept        = s_axis.tvalid && s_axis.tready;
  assign flush_go      = (state == ST_FLUSH) && out_free;

  assign m_axis.tdata  = m_data;
  assign m_axis.tvalid = m_valid;
  assign m_axis.tkeep  = '1;
  assign m_axis.tlast  = 1'b0;

  axis_tlast_strip_byte_packer u_packer (
    .clk        (aclk),
    .rst_n      (aresetn),
    .beat_en    (accept),
    .beat_data  (s_axis.tdata),
    .beat_n     (beat_n),
    .flush_en   (flush_go),
    .word_full  (word_full),
    .word_data  (word_data),
    .flush_data (flush_data),
    .post_count (post_count),
    .res_count  (res_count),
    .res_data   (res_data)
  );

  // Output register and RUN/FLUSH control; new loads only happen when out_free.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state   <= ST_RUN;
      m_valid <= 1'b0;
      m_data  <= '0;
    end else begin
      if (m_valid && m_axis.tready) m_valid <= 1'b0;
      case (state)
        ST_RUN: begin
          if (accept) begin
            if (word_full) begin
              m_valid <= 1'b1;
              m_data  <= word_data;
            end
            if (s_axis.tlast && FLUSH_ON_LAST && (post_count != 3'd0)) state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (out_free) begin
            m_valid <= 1'b1;
            m_data  <= flush_data;
            state   <= ST_RUN;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  // Clear has priority over any same-cycle increment or error.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pkt_count  <= '0;
      byte_count <= '0;
      keep_err   <= 1'b0;
    end else if (stat_clear) begin
      pkt_count  <= '0;
      byte_count <= '0;
      keep_err   <= 1'b0;
    end else if (accept) begin
      if (s_axis.tlast) pkt_count <= pkt_count + 1'b1;
      if (keep_legal) byte_count <= byte_count + COUNT_W'(beat_n);
      else            keep_err   <= 1'b1;
    end
  end

  assign dbg = '{state: state, res_count: res_count, res_data: res_data};

endmodule
